// File: rtl/texture_fetch_ctrl_if.sv
// Secondary (aux) read port into the texture ROM sequencer.
//   master : palette/debug reader. It drives req/addr and samples gnt/rvalid/rdata.
//   slave  : texture_fetch_ctrl.
//   req    : held until gnt; addr is stable while req is high.
//   gnt    : one-cycle pulse when the aux read is issued to the ROM.
//   rvalid : one-cycle pulse when rdata carries the returned word.
interface texture_fetch_ctrl_if #(
  parameter int unsigned TEX_LOG2 = 5
);
  localparam int unsigned AW = 2 * TEX_LOG2;

  logic          req;
  logic [AW-1:0] addr;
  logic          gnt;
  logic          rvalid;
  logic [15:0]   rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/texture_fetch_ctrl.sv
// texture_fetch_ctrl: sequences the synchronous texture ROM for the VGA pixel
// pipeline. It maps pixel coordinates to tiled and scrolled texel addresses.
// It realigns de/hs/vs with the ROM read latency. In blanking it arbitrates
// the ROM to a secondary (aux) reader, and video fetches always win.
//
// Ports:
//   clk, reset_n         pixel clock, async active-low reset
//   x, y, de_in, hs_in, vs_in   timing generator inputs
//   scroll_x, scroll_y   texel offsets, latched on the vsync active edge
//   aux                  aux read port (texture_fetch_ctrl_if.slave)
//   rom_ad, rom_ce       registered ROM address / clock enable
//   rom_oce, rom_reset   constant output enable, ROM reset (= ~reset_n)
//   rom_dout             ROM read data
//   rgb, de_out, hs_out, vs_out  pixel output, lagging inputs by ROM_LAT+2
//
// Build option: define TEXFETCH_MIRROR_EN for mirrored tiling. In that build,
// odd tile columns and odd tile rows reflect u and v.
module texture_fetch_ctrl #(
  parameter int unsigned TEX_LOG2 = 5,
  parameter int unsigned ROM_LAT  = 1,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [9:0]              x,
  input  logic [9:0]              y,
  input  logic                    de_in,
  input  logic                    hs_in,
  input  logic                    vs_in,
  input  logic [TEX_LOG2-1:0]     scroll_x,
  input  logic [TEX_LOG2-1:0]     scroll_y,
  texture_fetch_ctrl_if.slave     aux,
  output logic [2*TEX_LOG2-1:0]   rom_ad,
  output logic                    rom_ce,
  output logic                    rom_oce,
  output logic                    rom_reset,
  input  logic [15:0]             rom_dout,
  output logic [15:0]             rgb,
  output logic                    de_out,
  output logic                    hs_out,
  output logic                    vs_out
);

  localparam int unsigned TW = TEX_LOG2;
  localparam int unsigned AW = 2 * TEX_LOG2;
  localparam int unsigned TD = ROM_LAT + 1;  // read-in-flight tag depth
  localparam int unsigned PD = ROM_LAT + 2;  // video sideband delay depth

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_VIDEO = 2'd1,
    SLOT_AUX   = 2'd2
  } slot_e;

  slot_e         slot_c;
  logic [AW-1:0] ad_c;
  logic [TW:0]   u_sum_c;
  logic [TW:0]   v_sum_c;
  logic [TW-1:0] u_c;
  logic [TW-1:0] v_c;
  logic          vs_edge_c;

  logic [TW-1:0] sx_q;
  logic [TW-1:0] sy_q;
  logic          vs_prev_q;
  logic [TD-1:0] vid_tag_q;
  logic [TD-1:0] aux_tag_q;
  logic [PD-1:0] de_dly_q;
  logic [PD-1:0] hs_dly_q;
  logic [PD-1:0] vs_dly_q;

  // Only the low texel bits of x/y address the ROM. The upper bits are not
  // used, and the tile-parity carry is used only in the mirror build.
  logic unused_ok;
  assign unused_ok = &{1'b0, x[9:TW+1], y[9:TW+1], u_sum_c[TW], v_sum_c[TW]};

  assign rom_oce   = 1'b1;
  assign rom_reset = ~reset_n;

  assign vs_edge_c = (vs_in == VS_POL) && (vs_prev_q != VS_POL);

  // Slot selection and address generation. Video has priority over aux.
  always_comb begin
    slot_c  = SLOT_IDLE;
    ad_c    = rom_ad;
    // The sum carries one bit beyond the texel field. Bit TW is tile parity.
    u_sum_c = x[TW:0] + {1'b0, sx_q};
    v_sum_c = y[TW:0] + {1'b0, sy_q};
    u_c     = u_sum_c[TW-1:0];
    v_c     = v_sum_c[TW-1:0];
`ifdef TEXFETCH_MIRROR_EN
    if (u_sum_c[TW]) u_c = ~u_sum_c[TW-1:0];
    if (v_sum_c[TW]) v_c = ~v_sum_c[TW-1:0];
`endif
    if (de_in) begin
      slot_c = SLOT_VIDEO;
      ad_c   = {v_c, u_c};
    end else if (aux.req) begin
      slot_c = SLOT_AUX;
      ad_c   = aux.addr;
    end
  end

  // ROM request, tag pipeline, sideband delay and result capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_ad     <= '0;
      rom_ce     <= 1'b0;
      aux.gnt    <= 1'b0;
      aux.rvalid <= 1'b0;
      aux.rdata  <= '0;
      rgb        <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      vs_prev_q  <= ~VS_POL;
      vid_tag_q  <= '0;
      aux_tag_q  <= '0;
      de_dly_q   <= '0;
      hs_dly_q   <= '1;
      vs_dly_q   <= '1;
    end else begin
      rom_ad    <= ad_c;
      rom_ce    <= (slot_c != SLOT_IDLE);
      aux.gnt   <= (slot_c == SLOT_AUX);

      vid_tag_q <= (vid_tag_q << 1) | TD'(slot_c == SLOT_VIDEO);
      aux_tag_q <= (aux_tag_q << 1) | TD'(slot_c == SLOT_AUX);
      de_dly_q  <= {de_dly_q[PD-2:0], de_in};
      hs_dly_q  <= {hs_dly_q[PD-2:0], hs_in};
      vs_dly_q  <= {vs_dly_q[PD-2:0], vs_in};

      // The tag at the last stage tells which requester owns rom_dout now.
      aux.rvalid <= aux_tag_q[TD-1];
      if (aux_tag_q[TD-1]) aux.rdata <= rom_dout;
      rgb <= (vid_tag_q[TD-1] && de_dly_q[PD-2]) ? rom_dout : 16'h0000;

      // Scroll takes effect once per frame, on the vsync active edge.
      vs_prev_q <= vs_in;
      if (vs_edge_c) begin
        sx_q <= scroll_x;
        sy_q <= scroll_y;
      end
    end
  end

  assign de_out = de_dly_q[PD-1];
  assign hs_out = hs_dly_q[PD-1];
  assign vs_out = vs_dly_q[PD-1];

endmodule
